// File: rtl/cnv_pool2x2_pkg.sv
// Shared constants and per-channel arithmetic for the conv post-processing stages
// (ReLU, signed max, pixel-wide max).
package cnv_pool2x2_pkg;

    localparam int unsigned NCH   = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned PIX_W = NCH * DW;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } row_state_e;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x,
                                                  input logic              en);
        return (en && x[DW-1]) ? '0 : x;
    endfunction

    // Channelwise signed max of two packed pixels
    function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] res;
        res = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            res[k*DW +: DW] = smax(a[k*DW +: DW], b[k*DW +: DW]);
        end
        return res;
    endfunction

endpackage

// File: rtl/cnv_linebuf.sv
// Simple depth x width RAM: one synchronous write port, one combinational read port.
// Contents are intentionally not reset.
module cnv_linebuf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DWID  = 128,
    parameter int unsigned AW    = 6
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DWID-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [DWID-1:0] o_rdata_c
);

    logic [DWID-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/cnv_pool2x2.sv
// ReLU + 2x2 stride-2 max-pool over a raster stream of NCH-channel pixels,
// using a half-width line buffer holding horizontal maxima of the even row.
module cnv_pool2x2
    import cnv_pool2x2_pkg::*;
#(
    parameter int unsigned WIDTH   = 128,
    parameter int unsigned HEIGHT  = 128,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           vld_i,
    input  logic                           sof_i,
    input  logic [NCH*DW-1:0]              din,
    output logic                           vld_o,
    output logic [NCH*DW-1:0]              dout,
    output logic [$clog2(HEIGHT/2)-1:0]    pool_row,
    output logic [$clog2(WIDTH/2)-1:0]     pool_col,
    output logic                           frame_done
);

    localparam int unsigned CW  = $clog2(WIDTH);
    localparam int unsigned RW  = $clog2(HEIGHT);
    localparam int unsigned PCW = $clog2(WIDTH/2);
    localparam int unsigned PRW = $clog2(HEIGHT/2);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_hold;
    row_state_e       r_state;

    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    row_state_e       w_state_cur;
    row_state_e       w_state_nxt;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_lb_we;
    logic             w_emit;
    logic [PCW-1:0]   w_lb_addr;
    logic [PIX_W-1:0] w_pix;
    logic [PIX_W-1:0] w_hmax;
    logic [PIX_W-1:0] w_lb_rdata;
    logic [PIX_W-1:0] w_pool;

    // Effective position of the current pixel; sof_i resyncs to (0,0) in EVEN_ROW
    always_comb begin
        w_col       = r_col;
        w_row       = r_row;
        w_state_cur = r_state;
        if (sof_i) begin
            w_col       = '0;
            w_row       = '0;
            w_state_cur = EVEN_ROW;
        end
        w_col_last = (w_col == CW'(WIDTH - 1));
        w_row_last = (w_row == RW'(HEIGHT - 1));
        w_lb_addr  = PCW'(w_col >> 1);
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_lb_we     = 1'b0;
        w_emit      = 1'b0;
        if (vld_i) begin
            w_state_nxt = w_state_cur;
            if (w_col_last) begin
                w_state_nxt = (w_state_cur == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            end
            if (w_col[0]) begin
                w_lb_we = (w_state_cur == EVEN_ROW);
                w_emit  = (w_state_cur == ODD_ROW);
            end
        end
    end

    always_comb begin
        w_pix = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            w_pix[k*DW +: DW] = relu(din[k*DW +: DW], RELU_EN);
        end
        w_hmax = pix_max(r_hold, w_pix);
        w_pool = pix_max(w_hmax, w_lb_rdata);
    end

    cnv_linebuf #(
        .DEPTH (WIDTH / 2),
        .DWID  (PIX_W),
        .AW    (PCW)
    ) u_linebuf (
        .clk       (clk),
        .i_we      (w_lb_we),
        .i_waddr   (w_lb_addr),
        .i_wdata   (w_hmax),
        .i_raddr   (w_lb_addr),
        .o_rdata_c (w_lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EVEN_ROW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hold     <= '0;
            vld_o      <= 1'b0;
            dout       <= '0;
            pool_row   <= '0;
            pool_col   <= '0;
            frame_done <= 1'b0;
        end else begin
            vld_o      <= w_emit;
            frame_done <= w_emit && w_row_last && w_col_last;
            if (vld_i) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
                if (!w_col[0]) begin
                    r_hold <= w_pix;
                end
            end
            if (w_emit) begin
                dout     <= w_pool;
                pool_row <= PRW'(w_row >> 1);
                pool_col <= PCW'(w_col >> 1);
            end
        end
    end

endmodule

// File: tb/tb_cnv_pool2x2.sv
// Directed + randomized bench for cnv_pool2x2 on a 4x4 frame, with ReLU on and off,
// checked against a window-max reference computed from a stored frame image.
module tb_cnv_pool2x2;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 128;

    logic          clk;
    logic          rst;
    logic          vld_i;
    logic          sof_i;
    logic [PW-1:0] din;

    logic          vld_r, fd_r, vld_l, fd_l;
    logic [PW-1:0] dout_r, dout_l;
    logic [0:0]    pr_r, pc_r, pr_l, pc_l;

    int            n_cmp;
    int            n_err;
    int            n_vld;
    int            n_fd;
    int            mr;
    int            mc;
    logic [PW-1:0] pix [H][W];
    logic [PW-1:0] ed_r;
    logic [PW-1:0] ed_l;
    logic [7:0]    q_ch0 [$];

    cnv_pool2x2 #(.WIDTH(W), .HEIGHT(H), .RELU_EN(1'b1)) u_relu (
        .clk(clk), .rst(rst), .vld_i(vld_i), .sof_i(sof_i), .din(din),
        .vld_o(vld_r), .dout(dout_r), .pool_row(pr_r), .pool_col(pc_r),
        .frame_done(fd_r)
    );

    cnv_pool2x2 #(.WIDTH(W), .HEIGHT(H), .RELU_EN(1'b0)) u_lin (
        .clk(clk), .rst(rst), .vld_i(vld_i), .sof_i(sof_i), .din(din),
        .vld_o(vld_l), .dout(dout_l), .pool_row(pr_l), .pool_col(pc_l),
        .frame_done(fd_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Max over the 2x2 window ending at (r,c), per channel, as plain integers
    function automatic logic [PW-1:0] ref_pool(input int r, input int c, input bit relu_on);
        logic [PW-1:0]     res;
        logic signed [7:0] b;
        int                m;
        int                x;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            m = -1000;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    b = pix[r-1+dr][c-1+dc][k*8 +: 8];
                    x = b;
                    if (relu_on && x < 0) x = 0;
                    if (x > m) m = x;
                end
            end
            res[k*8 +: 8] = 8'(m);
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [PW-1:0] make_pix(input int mode, input int r, input int c);
        logic [PW-1:0] d;
        if (mode == 0) begin
            d = {16{8'(16*r + c)}};
        end else if (mode == 1) begin
            d = rnd128();
            d[7:0]     = 8'hFB;
            d[127:120] = 8'h80;
        end else begin
            d = rnd128();
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [PW-1:0] d);
        logic ev;
        logic efd;
        int   er;
        int   ec;
        ev = 1'b0; efd = 1'b0; er = 0; ec = 0;
        vld_i = v; sof_i = s; din = d;
        if (v) begin
            if (s) begin mr = 0; mc = 0; end
            pix[mr][mc] = d;
            if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                ev   = 1'b1;
                efd  = (mr == H-1) && (mc == W-1);
                er   = mr / 2;
                ec   = mc / 2;
                ed_r = ref_pool(mr, mc, 1'b1);
                ed_l = ref_pool(mr, mc, 1'b0);
            end
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        chk("vld_o_relu", PW'(vld_r), PW'(ev));
        chk("vld_o_lin",  PW'(vld_l), PW'(ev));
        chk("frame_done_relu", PW'(fd_r), PW'(efd));
        chk("frame_done_lin",  PW'(fd_l), PW'(efd));
        chk("dout_relu", dout_r, ed_r);
        chk("dout_lin",  dout_l, ed_l);
        if (ev) begin
            chk("pool_row", PW'(pr_r), PW'(er));
            chk("pool_col", PW'(pc_r), PW'(ec));
            chk("pool_row_lin", PW'(pr_l), PW'(er));
            chk("pool_col_lin", PW'(pc_l), PW'(ec));
        end
        if (vld_r) begin
            n_vld++;
            q_ch0.push_back(dout_r[7:0]);
        end
        if (fd_r) n_fd++;
    endtask

    task automatic do_reset();
        rst = 1'b1; vld_i = 1'b0; sof_i = 1'b0; din = rnd128();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mr = 0; mc = 0;
        ed_r = '0; ed_l = '0;
        chk("rst_vld_o", PW'({vld_r, vld_l}), PW'(0));
        chk("rst_frame_done", PW'({fd_r, fd_l}), PW'(0));
        chk("rst_dout_relu", dout_r, '0);
        chk("rst_dout_lin", dout_l, '0);
        chk("rst_pool_pos", PW'({pr_r, pc_r, pr_l, pc_l}), PW'(0));
    endtask

    task automatic send_frame(input int mode, input int gap, input bit sof_first);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, sof_first && (r == 0) && (c == 0), make_pix(mode, r, c));
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'($urandom()), rnd128());
                end
            end
        end
    endtask

    task automatic chk_ramp_seq(input string tag);
        chk({tag, "_count"}, PW'(q_ch0.size()), PW'(4));
        if (q_ch0.size() == 4) begin
            chk({tag, "_ch0_0"}, PW'(q_ch0[0]), PW'(17));
            chk({tag, "_ch0_1"}, PW'(q_ch0[1]), PW'(19));
            chk({tag, "_ch0_2"}, PW'(q_ch0[2]), PW'(49));
            chk({tag, "_ch0_3"}, PW'(q_ch0[3]), PW'(51));
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_vld = 0; n_fd = 0;
        mr = 0; mc = 0;
        rst = 1'b1; vld_i = 1'b0; sof_i = 1'b0; din = '0;
        ed_r = '0; ed_l = '0;

        do_reset();

        // Ramp frame
        q_ch0.delete();
        n_fd = 0;
        send_frame(0, 0, 1'b1);
        chk_ramp_seq("ramp");
        chk("ramp_fd_count", PW'(n_fd), PW'(1));

        // Negative channels with ReLU on/off
        send_frame(1, 0, 1'b1);
        chk("neg_relu_ch0",  PW'(dout_r[7:0]),     PW'(8'h00));
        chk("neg_relu_ch15", PW'(dout_r[127:120]), PW'(8'h00));
        chk("neg_lin_ch0",   PW'(dout_l[7:0]),     PW'(8'hFB));
        chk("neg_lin_ch15",  PW'(dout_l[127:120]), PW'(8'h80));

        // Ramp with 3-cycle gaps, no sof (follows previous frame directly)
        q_ch0.delete();
        send_frame(0, 3, 1'b0);
        chk_ramp_seq("gap");

        // Two back-to-back random frames
        n_vld = 0; n_fd = 0;
        send_frame(2, 0, 1'b1);
        send_frame(2, 0, 1'b1);
        chk("b2b_vld_count", PW'(n_vld), PW'(8));
        chk("b2b_fd_count",  PW'(n_fd),  PW'(2));

        // Reset after pixel (2,1), then replay the ramp frame
        for (int i = 0; i < 2*W + 2; i++) begin
            step(1'b1, (i == 0), rnd128());
        end
        do_reset();
        q_ch0.delete();
        send_frame(0, 0, 1'b0);
        chk_ramp_seq("post_rst");

        // Resync at pixel (1,2): abandoned window must not emit
        for (int i = 0; i < W + 2; i++) begin
            step(1'b1, (i == 0), rnd128());
        end
        n_vld = 0; n_fd = 0;
        send_frame(2, 0, 1'b1);
        chk("resync_vld_count", PW'(n_vld), PW'(4));
        chk("resync_fd_count",  PW'(n_fd),  PW'(1));

        // Random frames with random gaps and stray sof_i during gaps
        for (int f = 0; f < 4; f++) begin
            send_frame(2, $urandom_range(0, 2), 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnv_pool2x2.md
Name: cnv_pool2x2

Overview:
- Downstream of the 16-MAC convolution stage; consumes one 16-channel output pixel per valid cycle in raster order (the 8-bit-per-channel all_acc_o bus).
- Applies ReLU, then 2x2 stride-2 max-pooling per channel using a half-width line buffer.
- Emits one pooled 16-channel pixel per 2x2 window, plus a frame-done pulse on the final pooled pixel.

Parameters:
- WIDTH, 128, input pixels per row; must be even.
- HEIGHT, 128, input rows per frame; must be even.
- NCH, 16, channels per pixel.
- DW, 8, bits per channel, signed two's complement.
- RELU_EN, 1, 1 = negative values are clamped to 0 before pooling; 0 = pure signed max-pool.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- vld_i  in  1  input pixel valid.
- sof_i  in  1  start of frame; when high with vld_i, that pixel is (row 0, col 0).
- din  in  NCH*DW  channel k at bits [DW*(k+1)-1 -: DW], same packing as the conv output bus.
- vld_o  out  1  pooled pixel valid, one-cycle pulse.
- dout  out  NCH*DW  pooled pixel, same channel packing as din.
- pool_row  out  log2(HEIGHT/2)  output row index of dout.
- pool_col  out  log2(WIDTH/2)  output column index of dout.
- frame_done  out  1  one-cycle pulse, coincident with the last vld_o of the frame.

Behaviour:
- Reset values: vld_o=0, dout=0, pool_row=0, pool_col=0, frame_done=0. Internal row/col counters are 0, the hold register is 0, the state is EVEN_ROW.
- Per-channel pre-processing: v = RELU_EN ? (x<0 ? 0 : x) : x. All compares are signed DW-bit; no widening is needed.
- Counters: col counts 0..WIDTH-1 and advances only on vld_i. On wrap, row advances 0..HEIGHT-1; after the last pixel both counters return to 0.
- vld_i low stalls everything. All state is held and the output pulses stay 0. Gaps of any length are legal.
- sof_i with vld_i forces the current pixel to (0,0), overriding the counters. This gives mid-frame resync; any partial window is discarded.
- Horizontal pair:
  - On an even col, the pre-processed pixel is stored in a hold register.
  - On an odd col, hmax = channelwise max(hold, pixel).
- State machine, two states; the transition happens on the valid pixel with col=WIDTH-1:
  - EVEN_ROW: on an odd col, write hmax to the line buffer at index col>>1. Toggles to ODD_ROW at end of row.
  - ODD_ROW: on an odd col, result = channelwise max(hmax, lbuf[col>>1]). Toggles to EVEN_ROW at end of row.
- State mirrors row[0]; it is kept explicit for sof_i handling.
- Line buffer: WIDTH/2 entries of NCH*DW bits. It needs one synchronous write port and one read port. The read may be combinational, or registered if the address is issued on the even-col cycle. Contents are not reset, because every even row fully rewrites them before they are read.
- Output latency: dout/vld_o are registered. vld_o rises on the cycle after the valid input pixel at (odd row, odd col). On that same edge, pool_row=row>>1 and pool_col=col>>1 are registered.
- Idle value: dout holds its last value when vld_o=0.
- frame_done: asserted with the vld_o for input pixel (HEIGHT-1, WIDTH-1).
- Back-to-back frames: the pixel after (HEIGHT-1, WIDTH-1) is (0,0) with no bubble required, whether or not sof_i is asserted.
- No backpressure. The consumer must accept every vld_o pulse.
- rst mid-frame: the next edge clears all outputs and counters and enters EVEN_ROW. The first pixel after reset is (0,0).

Decomposition:
- Shared package: NCH, DW, a pixel-bus width constant NCH*DW, a signed max function on DW bits, and the ReLU function. These are reusable by the later pooling and activation stages.
- One natural sub-module: cnv_linebuf, a parameterised depth x width single-write/single-read RAM. It maps to BRAM or distributed RAM.

Test Plan:
- WIDTH=HEIGHT=4, RELU_EN=1, all channels = 16·row+col (as signed 8-bit) -> four vld_o pulses. Channel 0 values are 17, 19, 49, 51, with pool (row,col) = (0,0), (0,1), (1,0), (1,1). frame_done occurs only with 51.
- WIDTH=HEIGHT=4, every pixel ch0=-5 and ch15=-128:
  - RELU_EN=1 -> all outputs have ch0=0 and ch15=0.
  - RELU_EN=0 -> ch0=-5 (0xFB) and ch15=-128 (0x80).
- Stream of test 1 with vld_i low for 3 cycles between every pixel -> identical dout sequence. vld_o falls 1 cycle after each qualifying pixel, and there are no extra pulses.
- Two back-to-back frames, sof_i on each (0,0), no gap -> 8 vld_o pulses and 2 frame_done pulses. Second-frame outputs are unaffected by first-frame line buffer contents.
- Assert rst after input pixel (2,1) of frame 1, then restart the frame -> all outputs are 0 on the edge after rst, and the restarted frame reproduces the test-1 results exactly.
- sof_i asserted at pixel (1,2) of frame 1, then a full frame follows -> there is no vld_o for the abandoned window, and the new frame gives exactly 4 correct outputs.
